sram_io_bridge: RTL and testbench

SRAM_IO_BRIDGE -- requirements
Module: sram_io_bridge

---
 rtl/sram_io_bridge.sv | 190 +++++++++++++++++++
 tb/tb_sram_io_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_io_bridge.sv
// sram_io_bridge: bridges the SLC-3 MAR/MDR datapath to a 16-bit async SRAM,
// with a memory-mapped I/O word at x'FFFF (reads Switches, writes HexOut).
// Ports:
//   Clk, Reset               - single clock, synchronous active-high reset
//   Req, Write, Addr, WrData - CPU request; sampled only while IDLE
//   RdData, Ready, Busy      - registered read data, 1-cycle done pulse, busy flag
//   Switches, HexOut         - board I/O at x'FFFF
//   ADDR, Data, CE/UB/LB/OE/WE - SRAM address, shared data bus, active-low strobes
module sram_io_bridge (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Write,
  input  logic [15:0] Addr,
  input  logic [15:0] WrData,
  output logic [15:0] RdData,
  output logic        Ready,
  output logic        Busy,
  input  logic [15:0] Switches,
  output logic [15:0] HexOut,
  output logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE
);

  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WR1,
    WR2,
    WR3,
    IO,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  // Request fields captured on acceptance; the CPU may change its inputs
  // freely while the transaction is in flight.
  logic [15:0] addr_lat;
  logic [15:0] wdata_lat;
  logic        write_lat;

  logic        accept;
  logic        drive_data;

  assign accept = (state == IDLE) && Req;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and strobe decode. Strobes are a pure function of the
  // registered state, so they are glitch-free relative to Clk and all
  // return to inactive on the edge that applies Reset.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    CE         = 1'b1;
    UB         = 1'b1;
    LB         = 1'b1;
    OE         = 1'b1;
    WE         = 1'b1;
    Ready      = 1'b0;
    Busy       = 1'b1;
    drive_data = 1'b0;

    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Req) begin
          // Addr/Write seen here are exactly what addr_lat/write_lat capture
          // on this same edge.
          if (Addr == IO_ADDR) begin
            state_next = IO;
          end else if (Write) begin
            state_next = WR1;
          end else begin
            state_next = RD1;
          end
        end
      end
      RD1: begin
        CE         = 1'b0;
        UB         = 1'b0;
        LB         = 1'b0;
        OE         = 1'b0;
        state_next = RD2;
      end
      RD2: begin
        CE         = 1'b0;
        UB         = 1'b0;
        LB         = 1'b0;
        OE         = 1'b0;
        state_next = DONE;
      end
      WR1: begin
        // Address and data settle a full cycle before WE falls.
        CE         = 1'b0;
        UB         = 1'b0;
        LB         = 1'b0;
        drive_data = 1'b1;
        state_next = WR2;
      end
      WR2: begin
        CE         = 1'b0;
        UB         = 1'b0;
        LB         = 1'b0;
        WE         = 1'b0;
        drive_data = 1'b1;
        state_next = WR3;
      end
      WR3: begin
        // Data held one cycle past the WE rising edge for hold time.
        CE         = 1'b0;
        UB         = 1'b0;
        LB         = 1'b0;
        drive_data = 1'b1;
        state_next = DONE;
      end
      IO: begin
        state_next = DONE;
      end
      DONE: begin
        Ready      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_lat  <= 16'h0000;
      wdata_lat <= 16'h0000;
      write_lat <= 1'b0;
    end else if (accept) begin
      addr_lat  <= Addr;
      wdata_lat <= WrData;
      write_lat <= Write;
    end
  end

  // ---------------------------------------------------------------------
  // Read data and hex display registers
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      RdData <= 16'h0000;
      HexOut <= 16'h0000;
    end else begin
      if (state == RD2) begin
        RdData <= Data;
      end
      if ((state == IO) && !write_lat) begin
        RdData <= Switches;
      end
      if ((state == IO) && write_lat) begin
        HexOut <= wdata_lat;
      end
    end
  end

  // SRAM is 1M words; the CPU only reaches the lowest 64K.
  assign ADDR = {4'b0000, addr_lat};

  assign Data = drive_data ? wdata_lat : 16'hzzzz;

endmodule

// File: tb/tb_sram_io_bridge.sv
module tb_sram_io_bridge;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req;
  logic        Write;
  logic [15:0] Addr;
  logic [15:0] WrData;
  logic [15:0] RdData;
  logic        Ready;
  logic        Busy;
  logic [15:0] Switches;
  logic [15:0] HexOut;
  logic [19:0] ADDR;
  wire  [15:0] Data;
  logic        CE, UB, LB, OE, WE;

  localparam logic [15:0] PROBE  = 16'h5A5A;
  localparam int          LAT_RD = 3;
  localparam int          LAT_WR = 4;
  localparam int          LAT_IO = 2;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // SRAM model contents and reference model state
  logic [15:0] mem     [0:1023];
  logic [15:0] mem_ref [0:1023];
  logic [15:0] rd_ref;
  logic [15:0] hex_ref;

  logic        load_en;
  logic [9:0]  load_addr;
  logic [15:0] load_dat;
  logic        probe_en;
  int          we_low_cycles = 0;

  always #5 Clk = ~Clk;

  sram_io_bridge dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Write(Write), .Addr(Addr),
    .WrData(WrData), .RdData(RdData), .Ready(Ready), .Busy(Busy),
    .Switches(Switches), .HexOut(HexOut), .ADDR(ADDR), .Data(Data),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE)
  );

  // Async SRAM: drives the bus while selected for read. When nothing else
  // drives, the bench can place a probe pattern to reveal DUT bus drive.
  wire sram_drive = !CE && !OE && WE;
  assign Data = sram_drive ? mem[ADDR[9:0]] : (probe_en ? PROBE : 16'hzzzz);

  always @(posedge Clk) begin
    if (load_en) mem[load_addr] <= load_dat;
    else if (!CE && !WE) mem[ADDR[9:0]] <= Data;
    if (!WE) we_low_cycles <= we_low_cycles + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request from IDLE and collect what happened until Ready.
  task automatic run_txn(input logic wr, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output int ce_low, output int oe_low,
                         output int we_low, output logic [15:0] we_dat, output int addr_bad);
    lat = -1; ce_low = 0; oe_low = 0; we_low = 0; we_dat = 16'h0000; addr_bad = 0;
    Req = 1'b1; Write = wr; Addr = a; WrData = d;
    @(posedge Clk); #1;
    Req = 1'b0; Write = 1'($urandom_range(0, 1)); Addr = 16'($urandom); WrData = 16'($urandom);
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      if (!CE) ce_low++;
      if (!OE) oe_low++;
      if (!WE) begin we_low++; we_dat = Data; end
      if (ADDR !== {4'h0, a}) addr_bad++;
      if (Ready) begin lat = c; break; end
    end
    @(posedge Clk); #1;
  endtask

  task automatic preload;
    load_en = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      load_addr = 10'(i);
      load_dat  = (i == 16'h0030) ? 16'h1234 : 16'($urandom);
      mem_ref[i] = load_dat;
      @(posedge Clk); #1;
    end
    load_en = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1; Req = 1'b1; Write = 1'b0; Addr = 16'h0030; probe_en = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    rd_ref = 16'h0000; hex_ref = 16'h0000;
    chk_cnt++; if (RdData !== rd_ref) $display("FAIL reset_rddata: got %h want %h", RdData, rd_ref); else pass_cnt++;
    chk_cnt++; if (HexOut !== hex_ref) $display("FAIL reset_hexout: got %h want %h", HexOut, hex_ref); else pass_cnt++;
    chk_cnt++; if (ADDR !== 20'h0) $display("FAIL reset_addr: got %h want 00000", ADDR); else pass_cnt++;
    chk_cnt++; if ({CE, UB, LB, OE, WE} !== 5'b11111) $display("FAIL reset_strobes: got %b want 11111", {CE, UB, LB, OE, WE}); else pass_cnt++;
    chk_cnt++; if (Data !== PROBE) $display("FAIL reset_data_hiz: bus %h want probe %h", Data, PROBE); else pass_cnt++;
    chk_cnt++; if (Ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", Ready); else pass_cnt++;
    chk_cnt++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else pass_cnt++;
    // Req present on the reset edges must not start anything.
    Reset = 1'b0; Req = 1'b0; probe_en = 1'b0;
    @(posedge Clk); @(negedge Clk);
    chk_cnt++; if (Busy !== 1'b0) $display("FAIL reset_req_discard: busy %b want 0", Busy); else pass_cnt++;
    @(posedge Clk); #1;
  endtask

  task automatic test_sram_read;
    int lat, ce, oe, we, ab; logic [15:0] wd;
    rd_ref = mem_ref[10'h030];
    run_txn(1'b0, 16'h0030, 16'h0000, lat, ce, oe, we, wd, ab);
    chk_cnt++; if (lat !== LAT_RD) $display("FAIL read_latency: got %0d want %0d", lat, LAT_RD); else pass_cnt++;
    chk_cnt++; if (ce !== 2) $display("FAIL read_ce_cycles: got %0d want 2", ce); else pass_cnt++;
    chk_cnt++; if (oe !== 2) $display("FAIL read_oe_cycles: got %0d want 2", oe); else pass_cnt++;
    chk_cnt++; if (we !== 0) $display("FAIL read_we_cycles: got %0d want 0", we); else pass_cnt++;
    chk_cnt++; if (ab !== 0) $display("FAIL read_addr_stable: %0d bad cycles", ab); else pass_cnt++;
    chk_cnt++; if (RdData !== rd_ref) $display("FAIL read_data: got %h want %h", RdData, rd_ref); else pass_cnt++;
  endtask

  task automatic test_write_read;
    int lat, ce, oe, we, ab; logic [15:0] wd;
    run_txn(1'b1, 16'h0031, 16'hABCD, lat, ce, oe, we, wd, ab);
    mem_ref[10'h031] = 16'hABCD;
    chk_cnt++; if (lat !== LAT_WR) $display("FAIL write_latency: got %0d want %0d", lat, LAT_WR); else pass_cnt++;
    chk_cnt++; if (we !== 1) $display("FAIL write_we_cycles: got %0d want 1", we); else pass_cnt++;
    chk_cnt++; if (wd !== 16'hABCD) $display("FAIL write_we_data: got %h want abcd", wd); else pass_cnt++;
    chk_cnt++; if (ce !== 3) $display("FAIL write_ce_cycles: got %0d want 3", ce); else pass_cnt++;
    chk_cnt++; if (oe !== 0) $display("FAIL write_oe_cycles: got %0d want 0", oe); else pass_cnt++;
    chk_cnt++; if (ab !== 0) $display("FAIL write_addr_stable: %0d bad cycles", ab); else pass_cnt++;
    chk_cnt++; if (mem[10'h031] !== mem_ref[10'h031]) $display("FAIL write_sram_content: got %h want %h", mem[10'h031], mem_ref[10'h031]); else pass_cnt++;
    chk_cnt++; if (RdData !== rd_ref) $display("FAIL write_keeps_rddata: got %h want %h", RdData, rd_ref); else pass_cnt++;
    run_txn(1'b0, 16'h0031, 16'h0000, lat, ce, oe, we, wd, ab);
    rd_ref = mem_ref[10'h031];
    chk_cnt++; if (lat !== LAT_RD) $display("FAIL readback_latency: got %0d want %0d", lat, LAT_RD); else pass_cnt++;
    chk_cnt++; if (RdData !== rd_ref) $display("FAIL readback_data: got %h want %h", RdData, rd_ref); else pass_cnt++;
  endtask

  task automatic test_io;
    int lat, ce, oe, we, ab; logic [15:0] wd;
    Switches = 16'h00F5;
    run_txn(1'b0, 16'hFFFF, 16'h0000, lat, ce, oe, we, wd, ab);
    rd_ref = Switches;
    chk_cnt++; if (lat !== LAT_IO) $display("FAIL io_read_latency: got %0d want %0d", lat, LAT_IO); else pass_cnt++;
    chk_cnt++; if (RdData !== rd_ref) $display("FAIL io_read_data: got %h want %h", RdData, rd_ref); else pass_cnt++;
    chk_cnt++; if (ce !== 0) $display("FAIL io_read_ce: got %0d want 0", ce); else pass_cnt++;
    run_txn(1'b1, 16'hFFFF, 16'hBEEF, lat, ce, oe, we, wd, ab);
    hex_ref = 16'hBEEF;
    chk_cnt++; if (lat !== LAT_IO) $display("FAIL io_write_latency: got %0d want %0d", lat, LAT_IO); else pass_cnt++;
    chk_cnt++; if (HexOut !== hex_ref) $display("FAIL io_write_hex: got %h want %h", HexOut, hex_ref); else pass_cnt++;
    chk_cnt++; if (ce !== 0 || we !== 0) $display("FAIL io_write_strobes: ce %0d we %0d want 0 0", ce, we); else pass_cnt++;
    chk_cnt++; if (RdData !== rd_ref) $display("FAIL io_write_keeps_rddata: got %h want %h", RdData, rd_ref); else pass_cnt++;
  endtask

  task automatic test_random;
    int lat, ce, oe, we, ab, exp_lat, exp_ce, exp_we, diffs;
    logic [15:0] wd, a, d;
    logic io, wr;
    for (int n = 0; n < 40; n++) begin
      io = ($urandom_range(0, 3) == 0);
      wr = 1'($urandom_range(0, 1));
      a  = io ? 16'hFFFF : 16'h0100 + 16'($urandom_range(0, 63));
      d  = 16'($urandom);
      Switches = 16'($urandom);
      if (io) begin
        if (wr) hex_ref = d; else rd_ref = Switches;
        exp_ce = 0; exp_lat = LAT_IO;
      end else begin
        if (wr) mem_ref[a[9:0]] = d; else rd_ref = mem_ref[a[9:0]];
        exp_ce = wr ? 3 : 2; exp_lat = wr ? LAT_WR : LAT_RD;
      end
      exp_we = (wr && !io) ? 1 : 0;
      run_txn(wr, a, d, lat, ce, oe, we, wd, ab);
      chk_cnt++; if (lat !== exp_lat) $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, exp_lat); else pass_cnt++;
      chk_cnt++; if (RdData !== rd_ref) $display("FAIL rand_rddata[%0d]: got %h want %h", n, RdData, rd_ref); else pass_cnt++;
      chk_cnt++; if (HexOut !== hex_ref) $display("FAIL rand_hexout[%0d]: got %h want %h", n, HexOut, hex_ref); else pass_cnt++;
      chk_cnt++; if (ce !== exp_ce || we !== exp_we) $display("FAIL rand_strobes[%0d]: ce %0d we %0d want %0d %0d", n, ce, we, exp_ce, exp_we); else pass_cnt++;
      if (!io) begin
        chk_cnt++; if (ab !== 0) $display("FAIL rand_addr_stable[%0d]: %0d bad cycles", n, ab); else pass_cnt++;
      end
    end
    diffs = 0;
    for (int i = 16'h0100; i < 16'h0140; i++) if (mem[i] !== mem_ref[i]) diffs++;
    chk_cnt++; if (diffs !== 0) $display("FAIL rand_sram_contents: %0d words differ, want 0", diffs); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] a_seq [16];
    logic        rdy   [16];
    logic [19:0] adr   [16];
    logic [15:0] rdv   [16];
    logic [15:0] cur;
    int acc, next_acc, ph;
    logic exp_rdy;
    Req = 1'b1; Write = 1'b0;
    @(negedge Clk);
    for (int i = 0; i < 16; i++) begin
      a_seq[i] = $urandom_range(0, 1) ? 16'h0011 : 16'h0010;
      Addr = a_seq[i];
      @(posedge Clk); @(negedge Clk);
      rdy[i] = Ready; adr[i] = ADDR; rdv[i] = RdData;
    end
    Req = 1'b0;
    for (int k = 0; k < 10 && Busy; k++) @(negedge Clk);
    @(posedge Clk); #1;
    // A read occupies LAT_RD cycles plus the return to IDLE, so with Req
    // held the bridge accepts every LAT_RD+1 edges.
    acc = 0; next_acc = 0; cur = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (i == next_acc) begin acc = i; cur = a_seq[i]; next_acc = i + LAT_RD + 1; end
      ph = i - acc;
      exp_rdy = (ph == LAT_RD - 1);
      chk_cnt++; if (rdy[i] !== exp_rdy) $display("FAIL b2b_ready[%0d]: got %b want %b", i, rdy[i], exp_rdy); else pass_cnt++;
      if (ph < LAT_RD) begin
        chk_cnt++; if (adr[i] !== {4'h0, cur}) $display("FAIL b2b_addr[%0d]: got %h want %h", i, adr[i], {4'h0, cur}); else pass_cnt++;
      end
      if (exp_rdy) begin
        rd_ref = mem_ref[cur[9:0]];
        chk_cnt++; if (rdv[i] !== rd_ref) $display("FAIL b2b_rddata[%0d]: got %h want %h", i, rdv[i], rd_ref); else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_wr1;
    logic [15:0] old; int we_before;
    old = mem_ref[10'h040]; we_before = we_low_cycles;
    Req = 1'b1; Write = 1'b1; Addr = 16'h0040; WrData = 16'hA5A5;
    @(posedge Clk); #1;
    Req = 1'b0; Reset = 1'b1;
    @(posedge Clk); #1;
    probe_en = 1'b1;
    @(negedge Clk);
    rd_ref = 16'h0000; hex_ref = 16'h0000;
    chk_cnt++; if ({CE, UB, LB, OE, WE} !== 5'b11111) $display("FAIL wr1_reset_strobes: got %b want 11111", {CE, UB, LB, OE, WE}); else pass_cnt++;
    chk_cnt++; if (Data !== PROBE) $display("FAIL wr1_reset_data_hiz: bus %h want probe %h", Data, PROBE); else pass_cnt++;
    chk_cnt++; if (Ready !== 1'b0 || Busy !== 1'b0) $display("FAIL wr1_reset_ready_busy: got %b%b want 00", Ready, Busy); else pass_cnt++;
    chk_cnt++; if (we_low_cycles !== we_before) $display("FAIL wr1_reset_we_pulse: got %0d want %0d", we_low_cycles, we_before); else pass_cnt++;
    chk_cnt++; if (mem[10'h040] !== old) $display("FAIL wr1_reset_sram: got %h want %h", mem[10'h040], old); else pass_cnt++;
    Reset = 1'b0; probe_en = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_rd2;
    int lat, ce, oe, we, ab, readies; logic [15:0] wd;
    Switches = 16'h0F0F;
    run_txn(1'b1, 16'hFFFF, 16'h7777, lat, ce, oe, we, wd, ab);
    hex_ref = 16'h7777;
    run_txn(1'b0, 16'h0030, 16'h0000, lat, ce, oe, we, wd, ab);
    rd_ref = mem_ref[10'h030];
    chk_cnt++; if (RdData !== 16'h1234) $display("FAIL rd2_pre_rddata: got %h want 1234", RdData); else pass_cnt++;
    chk_cnt++; if (HexOut !== hex_ref) $display("FAIL rd2_pre_hexout: got %h want %h", HexOut, hex_ref); else pass_cnt++;
    Req = 1'b1; Write = 1'b0; Addr = 16'h0031;
    @(posedge Clk); #1;
    Req = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    rd_ref = 16'h0000; hex_ref = 16'h0000;
    @(negedge Clk);
    chk_cnt++; if (RdData !== rd_ref) $display("FAIL rd2_reset_rddata: got %h want %h", RdData, rd_ref); else pass_cnt++;
    chk_cnt++; if (Busy !== 1'b0) $display("FAIL rd2_reset_busy: got %b want 0", Busy); else pass_cnt++;
    chk_cnt++; if (HexOut !== hex_ref) $display("FAIL rd2_reset_hexout: got %h want %h", HexOut, hex_ref); else pass_cnt++;
    readies = 0;
    for (int k = 0; k < 4; k++) begin
      if (Ready) readies++;
      @(negedge Clk);
    end
    chk_cnt++; if (readies !== 0) $display("FAIL rd2_reset_no_ready: got %0d pulses want 0", readies); else pass_cnt++;
    @(posedge Clk); #1;
  endtask

  initial begin
    Reset = 1'b1; Req = 1'b0; Write = 1'b0; Addr = 16'h0000; WrData = 16'h0000;
    Switches = 16'h0000; probe_en = 1'b0; load_en = 1'b0; load_addr = 10'h0; load_dat = 16'h0;
    rd_ref = 16'h0000; hex_ref = 16'h0000;
    preload();
    test_reset();
    test_sram_read();
    test_write_read();
    test_io();
    test_random();
    test_back_to_back();
    test_reset_wr1();
    test_reset_rd2();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
